dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl.sv | 178 +++++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller: issues one bus transaction per
// aligned load/store, stalls EX/MEM until it completes, reports alignment and bus errors.
module dmem_access_ctrl #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_dmen,
   input  logic        mem_memwr,
   input  logic [31:0] mem_result,
   input  logic [31:0] mem_rt,
   input  logic [31:0] mem_pc_i,
   output logic        pa_idexmemwr,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic        dbus_gnt,
   input  logic        dbus_rvalid,
   input  logic [31:0] dbus_rdata,
   output logic [31:0] mem_rdata_o,
   output logic        mem_ack,
   output logic        align_err,
   output logic        bus_err,
   output logic [31:0] err_pc
);

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_RESP = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
   logic            r_req, w_req_nxt;
   logic            r_we, w_we_nxt;
   logic [DW-1:0]   r_addr, w_addr_nxt;
   logic [DW-1:0]   r_wdata, w_wdata_nxt;
   logic [DW-1:0]   r_pc, w_pc_nxt;
   logic [DW-1:0]   r_rdata, w_rdata_nxt;
   logic            r_ack, w_ack_nxt;
   logic            r_aerr, w_aerr_nxt;
   logic            r_berr, w_berr_nxt;
   logic [DW-1:0]   r_epc, w_epc_nxt;
   logic            w_aligned;
   logic            w_timeout;

   assign w_aligned = (mem_result[1:0] == 2'b00);
   assign w_cnt_inc = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
   // Abort once the access has spent TIMEOUT cycles in ADDR+RESP
   assign w_timeout = (32'(w_cnt_inc) >= TIMEOUT);

   // Next-state and next-register logic
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_req_nxt   = r_req;
      w_we_nxt    = r_we;
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_pc_nxt    = r_pc;
      w_rdata_nxt = r_rdata;
      w_ack_nxt   = 1'b0;
      w_aerr_nxt  = 1'b0;
      w_berr_nxt  = 1'b0;
      w_epc_nxt   = r_epc;
      case (r_state)
         S_IDLE: begin
            if (mem_dmen) begin
               if (w_aligned) begin
                  w_state_nxt = S_ADDR;
                  w_cnt_nxt   = '0;
                  w_req_nxt   = 1'b1;
                  w_we_nxt    = mem_memwr;
                  w_addr_nxt  = mem_result;
                  w_wdata_nxt = mem_rt;
                  w_pc_nxt    = mem_pc_i;
               end else begin
                  w_aerr_nxt = 1'b1;
                  w_epc_nxt  = mem_pc_i;
               end
            end
         end
         S_ADDR: begin
            w_cnt_nxt = w_cnt_inc;
            if (dbus_gnt) begin
               w_req_nxt = 1'b0;
               if (r_we) begin
                  w_state_nxt = S_DONE;
                  w_ack_nxt   = 1'b1;
               end else begin
                  w_state_nxt = S_RESP;
               end
            end else if (w_timeout) begin
               w_req_nxt   = 1'b0;
               w_state_nxt = S_DONE;
               w_ack_nxt   = 1'b1;
               w_berr_nxt  = 1'b1;
               w_epc_nxt   = r_pc;
               if (!r_we) begin
                  w_rdata_nxt = '0;
               end
            end
         end
         S_RESP: begin
            w_cnt_nxt = w_cnt_inc;
            if (dbus_rvalid) begin
               w_rdata_nxt = dbus_rdata;
               w_state_nxt = S_DONE;
               w_ack_nxt   = 1'b1;
            end else if (w_timeout) begin
               w_rdata_nxt = '0;
               w_state_nxt = S_DONE;
               w_ack_nxt   = 1'b1;
               w_berr_nxt  = 1'b1;
               w_epc_nxt   = r_pc;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_pc    <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_aerr  <= 1'b0;
         r_berr  <= 1'b0;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_req   <= w_req_nxt;
         r_we    <= w_we_nxt;
         r_addr  <= w_addr_nxt;
         r_wdata <= w_wdata_nxt;
         r_pc    <= w_pc_nxt;
         r_rdata <= w_rdata_nxt;
         r_ack   <= w_ack_nxt;
         r_aerr  <= w_aerr_nxt;
         r_berr  <= w_berr_nxt;
         r_epc   <= w_epc_nxt;
      end
   end

   // Stall is combinational so the first IDLE cycle of an access already holds EX/MEM
   assign pa_idexmemwr = ((r_state == S_IDLE) && mem_dmen && w_aligned) ||
                         (r_state == S_ADDR) || (r_state == S_RESP);

   assign dbus_req    = r_req;
   assign dbus_we     = r_we;
   assign dbus_addr   = r_addr;
   assign dbus_wdata  = r_wdata;
   assign mem_rdata_o = r_rdata;
   assign mem_ack     = r_ack;
   assign align_err   = r_aerr;
   assign bus_err     = r_berr;
   assign err_pc      = r_epc;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: table of accesses fed through a pipeline-like driver,
// a bus responder, and a scoreboard checked on each completion.
module tb_dmem_access_ctrl;

   localparam int unsigned TO    = 4;
   localparam int          NEVER = 1000;
   localparam int          NVEC  = 12;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_dmen, mem_memwr;
   logic [31:0] mem_result, mem_rt, mem_pc_i;
   logic        pa_idexmemwr;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic        dbus_gnt, dbus_rvalid;
   logic [31:0] dbus_rdata;
   logic [31:0] mem_rdata_o;
   logic        mem_ack, align_err, bus_err;
   logic [31:0] err_pc;

   dmem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .mem_dmen(mem_dmen), .mem_memwr(mem_memwr), .mem_result(mem_result),
      .mem_rt(mem_rt), .mem_pc_i(mem_pc_i), .pa_idexmemwr(pa_idexmemwr),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
      .dbus_rdata(dbus_rdata), .mem_rdata_o(mem_rdata_o), .mem_ack(mem_ack),
      .align_err(align_err), .bus_err(bus_err), .err_pc(err_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] pc;
      int          gnt_dly;
      int          rv_dly;
      logic [31:0] rdata;
      logic        exp_align;
      int          exp_lat;
      logic        exp_berr;
      logic [31:0] exp_rdata;
      logic [31:0] exp_epc;
   } vec_t;

   typedef struct {
      int          idx;
      logic        align;
      int          due;
      logic        berr;
      logic [31:0] rdata;
      logic [31:0] epc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   vec_t tbl [NVEC];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int n_reqs   = 0;
   int exp_reqs = 0;
   logic prev_req = 1'b0;

   // bus responder configuration
   int          gnt_dly = 0, rv_dly = 0, req_cnt = 0, rsp_cnt = 0;
   bit          rsp_pending = 1'b0;
   logic [31:0] rsp_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Bus slave: grant after gnt_dly request cycles, respond rv_dly cycles after a load grant
   always @(negedge clk) begin
      dbus_gnt    = 1'b0;
      dbus_rvalid = 1'b0;
      if (rsp_pending) begin
         if (rsp_cnt == rv_dly) begin
            dbus_rvalid = 1'b1;
            dbus_rdata  = rsp_data;
            rsp_pending = 1'b0;
         end else begin
            rsp_cnt++;
         end
      end
      if (dbus_req) begin
         if (req_cnt == gnt_dly) begin
            dbus_gnt = 1'b1;
            if (!dbus_we) begin
               rsp_pending = 1'b1;
               rsp_cnt     = 0;
            end
         end
         req_cnt++;
      end else begin
         req_cnt = 0;
      end
   end

   // Monitor: request stability against the current access, completions against the scoreboard
   always @(negedge clk) begin : mon
      exp_t e;
      if (reset) begin
         if (dbus_req && !prev_req) n_reqs++;
         prev_req = dbus_req;
         if (dbus_req) begin
            if (sb.size() == 0) begin
               chk("req_without_access", 32'(dbus_req), 32'd0);
            end else begin
               chk("req_addr", dbus_addr, sb[0].addr);
               chk("req_wdata", dbus_wdata, sb[0].wdata);
               chk("req_we", 32'(dbus_we), 32'(sb[0].we));
            end
         end
         if (mem_ack || align_err) begin
            if (sb.size() == 0) begin
               chk("unexpected_completion", 32'(mem_ack | align_err), 32'd0);
            end else begin
               e = sb.pop_front();
               chk($sformatf("v%0d_align_err", e.idx), 32'(align_err), 32'(e.align));
               chk($sformatf("v%0d_mem_ack", e.idx), 32'(mem_ack), 32'(!e.align));
               chk($sformatf("v%0d_latency", e.idx), 32'(cyc), 32'(e.due));
               chk($sformatf("v%0d_bus_err", e.idx), 32'(bus_err), 32'(e.berr));
               chk($sformatf("v%0d_rdata", e.idx), mem_rdata_o, e.rdata);
               chk($sformatf("v%0d_req_low", e.idx), 32'(dbus_req), 32'd0);
               if (e.align || e.berr) chk($sformatf("v%0d_err_pc", e.idx), err_pc, e.epc);
            end
         end
      end else begin
         prev_req = 1'b0;
      end
   end

   // Present one access and hold it while the stall is asserted, like the EX/MEM register
   task automatic issue(input vec_t v, input int idx);
      exp_t e;
      int   k;
      rsp_pending = 1'b0;
      gnt_dly     = v.gnt_dly;
      rv_dly      = v.rv_dly;
      rsp_data    = v.rdata;
      @(negedge clk);
      mem_dmen   = 1'b1;
      mem_memwr  = v.we;
      mem_result = v.addr;
      mem_rt     = v.wdata;
      mem_pc_i   = v.pc;
      e.idx   = idx;
      e.align = v.exp_align;
      e.due   = cyc + v.exp_lat;
      e.berr  = v.exp_berr;
      e.rdata = v.exp_rdata;
      e.epc   = v.exp_epc;
      e.we    = v.we;
      e.addr  = v.addr;
      e.wdata = v.wdata;
      sb.push_back(e);
      if (!v.exp_align) exp_reqs++;
      #1;
      chk($sformatf("v%0d_stall_first", idx), 32'(pa_idexmemwr), 32'(!v.exp_align));
      k = 0;
      while (pa_idexmemwr && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      if (pa_idexmemwr) chk($sformatf("v%0d_stall_bound", idx), 32'(pa_idexmemwr), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //            we    addr          wdata         pc            gnt    rv     rdata         al    lat berr  exp_rdata     exp_epc
      tbl[0]  = '{1'b0, 32'h0000_0100, 32'h0,        32'h0000_0010, 0,     0,     32'hDEADBEEF, 1'b0, 3,  1'b0, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b1, 32'h0000_0204, 32'h12345678, 32'h0000_0014, 2,     0,     32'h0,        1'b0, 4,  1'b0, 32'hDEADBEEF, 32'h0};
      tbl[2]  = '{1'b0, 32'h0000_0102, 32'h0,        32'h0000_0400, 0,     0,     32'h0,        1'b1, 1,  1'b0, 32'hDEADBEEF, 32'h0000_0400};
      tbl[3]  = '{1'b0, 32'h0000_0300, 32'h0,        32'h0000_0020, NEVER, 0,     32'h0,        1'b0, 5,  1'b1, 32'h0,        32'h0000_0020};
      tbl[4]  = '{1'b0, 32'h0000_0104, 32'h0,        32'h0000_0024, 0,     0,     32'hCAFEF00D, 1'b0, 3,  1'b0, 32'hCAFEF00D, 32'h0};
      tbl[5]  = '{1'b0, 32'h0000_0108, 32'h0,        32'h0000_0028, 1,     1,     32'h0BADC0DE, 1'b0, 5,  1'b0, 32'h0BADC0DE, 32'h0};
      tbl[6]  = '{1'b1, 32'h0000_010C, 32'hA5A5A5A5, 32'h0000_002C, 3,     0,     32'h0,        1'b0, 5,  1'b0, 32'h0BADC0DE, 32'h0};
      tbl[7]  = '{1'b0, 32'h0000_0110, 32'h0,        32'h0000_0030, 0,     2,     32'h55AA33CC, 1'b0, 5,  1'b0, 32'h55AA33CC, 32'h0};
      tbl[8]  = '{1'b0, 32'h0000_0114, 32'h0,        32'h0000_0034, 0,     NEVER, 32'h0,        1'b0, 5,  1'b1, 32'h0,        32'h0000_0034};
      tbl[9]  = '{1'b1, 32'h0000_0001, 32'h0,        32'h0000_0038, 0,     0,     32'h0,        1'b1, 1,  1'b0, 32'h0,        32'h0000_0038};
      tbl[10] = '{1'b1, 32'h0000_0118, 32'hFFFFFFFF, 32'h0000_003C, 0,     0,     32'h0,        1'b0, 2,  1'b0, 32'h0,        32'h0};
      tbl[11] = '{1'b0, 32'h0000_011C, 32'h0,        32'h0000_0040, 3,     0,     32'h13579BDF, 1'b0, 6,  1'b0, 32'h13579BDF, 32'h0};

      reset       = 1'b0;
      mem_dmen    = 1'b0;
      mem_memwr   = 1'b0;
      mem_result  = '0;
      mem_rt      = '0;
      mem_pc_i    = '0;
      dbus_gnt    = 1'b0;
      dbus_rvalid = 1'b0;
      dbus_rdata  = '0;

      // Reset values before any clock edge
      #2;
      chk("rst_dbus_req", 32'(dbus_req), 32'd0);
      chk("rst_dbus_addr", dbus_addr, 32'd0);
      chk("rst_dbus_wdata", dbus_wdata, 32'd0);
      chk("rst_mem_rdata", mem_rdata_o, 32'd0);
      chk("rst_flags", {29'd0, mem_ack, align_err, bus_err}, 32'd0);
      chk("rst_err_pc", err_pc, 32'd0);
      chk("rst_stall", 32'(pa_idexmemwr), 32'd0);

      repeat (2) @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < NVEC; i++) issue(tbl[i], i);

      // Reset while a load waits in RESP, then a stray response afterwards
      rsp_pending = 1'b0;
      gnt_dly     = 0;
      rv_dly      = NEVER;
      @(negedge clk);
      mem_dmen   = 1'b1;
      mem_memwr  = 1'b0;
      mem_result = 32'h0000_0500;
      mem_rt     = '0;
      mem_pc_i   = 32'h0000_0050;
      sb.push_back('{100, 1'b0, 0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0000_0500, 32'h0});
      exp_reqs++;
      repeat (2) @(negedge clk);
      #1;
      chk("resp_stall", 32'(pa_idexmemwr), 32'd1);
      chk("resp_req_low", 32'(dbus_req), 32'd0);
      #1;
      reset    = 1'b0;
      mem_dmen = 1'b0;
      #1;
      chk("midrst_stall", 32'(pa_idexmemwr), 32'd0);
      chk("midrst_rdata", mem_rdata_o, 32'd0);
      chk("midrst_flags", {29'd0, mem_ack, align_err, bus_err}, 32'd0);
      chk("midrst_err_pc", err_pc, 32'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      rsp_data    = 32'hAAAA5555;
      rv_dly      = 0;
      rsp_cnt     = 0;
      rsp_pending = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("stray_rdata", mem_rdata_o, 32'd0);
      chk("stray_stall", 32'(pa_idexmemwr), 32'd0);
      chk("stray_req", 32'(dbus_req), 32'd0);

      repeat (3) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      chk("bus_requests", 32'(n_reqs), 32'(exp_reqs));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
